// File: rtl/seq_pkg.sv
// Shared types and default preamble for the seq_generator / seq_detector pair.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_generator_if.sv
// Payload valid/ready handshake into the serial frame generator.
interface seq_generator_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/seq_generator.sv
// Serial frame transmitter: preamble, MSB-first payload, idle-zero gap.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit after the payload.
module seq_generator
    import seq_pkg::*;
#(
    parameter int                PAT_W      = DEF_PAT_W,
    parameter logic [PAT_W-1:0]  PATTERN    = DEF_PATTERN,
    parameter int                DATA_W     = 8,
    parameter int                GAP_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    seq_generator_if.slave up,
    output logic           seq_out,
    output logic           seq_active,
    output logic           frame_done
);

`ifdef SEQ_GEN_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int LEN = PAT_W + DATA_W + PAR_W;
    localparam int CW  = $clog2(LEN);
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic [LEN-1:0]  sh_q, sh_d;
    logic [LEN-1:0]  frame_w;
    logic            out_d, act_d, done_d, rdy_q, rdy_d;

`ifdef SEQ_GEN_PARITY_EN
    assign frame_w = {PATTERN, up.data_in, ^up.data_in};
`else
    assign frame_w = {PATTERN, up.data_in};
`endif

    assign up.data_ready = rdy_q;

    // cnt holds the number of frame bits still to come after the one on seq_out
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        sh_d    = sh_q;
        out_d   = 1'b0;
        act_d   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (up.data_valid) begin
                    state_d = SEND;
                    sh_d    = frame_w << 1;
                    out_d   = frame_w[LEN-1];
                    act_d   = 1'b1;
                    cnt_d   = CW'(LEN - 1);
                end
            end
            SEND: begin
                if (cnt_q != '0) begin
                    out_d  = sh_q[LEN-1];
                    sh_d   = sh_q << 1;
                    cnt_d  = cnt_q - 1'b1;
                    act_d  = 1'b1;
                    done_d = (cnt_q == CW'(1));
                end else if (GAP_CYCLES > 0) begin
                    state_d = GAP;
                    gcnt_d  = GW'(GAP_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gcnt_q == '0) state_d = IDLE;
                else              gcnt_d  = gcnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gcnt_q     <= '0;
            sh_q       <= '0;
            seq_out    <= 1'b0;
            seq_active <= 1'b0;
            frame_done <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gcnt_q     <= gcnt_d;
            sh_q       <= sh_d;
            seq_out    <= out_d;
            seq_active <= act_d;
            frame_done <= done_d;
            rdy_q      <= rdy_d;
        end
    end

endmodule

// File: tb/tb_seq_generator.sv
// Directed-vector bench for seq_generator (default parameters).
module tb_seq_generator;

`ifdef SEQ_GEN_PARITY_EN
    localparam int LEN = 13;
`else
    localparam int LEN = 12;
`endif
    localparam int GAPC = 2;
    localparam int PER  = LEN + GAPC + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic seq_out, seq_active, frame_done;

    int n_vec = 0;
    int n_err = 0;
    int det_cnt = 0;
    logic [3:0] win = '0;

    seq_generator_if #(.DATA_W(8)) bus ();

    seq_generator dut (
        .clk        (clk),
        .rst        (rst),
        .up         (bus),
        .seq_out    (seq_out),
        .seq_active (seq_active),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // stand-in for seq_detector: overlapping 1011 matcher on the line
    always @(negedge clk) begin
        win = {win[2:0], seq_out};
        if (win == 4'b1011) det_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] frame_of(input logic [7:0] d);
`ifdef SEQ_GEN_PARITY_EN
        return {3'b000, 4'b1011, d, ^d};
`else
        return {4'b0000, 4'b1011, d};
`endif
    endfunction

    function automatic logic fbit(input logic [7:0] d, input int i);
        logic [15:0] f;
        f = frame_of(d);
        return f[LEN-1-i];
    endfunction

    // called at a negedge while in IDLE; returns at the first IDLE negedge after
    task automatic run_frame(input logic [7:0] d);
        bus.data_in    = d;
        bus.data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.data_valid = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            chk($sformatf("bit%0d", i), seq_out, fbit(d, i));
            chk($sformatf("act%0d", i), seq_active, 1'b1);
            chk($sformatf("done%0d", i), frame_done, (i == LEN - 1));
            chk($sformatf("rdy%0d", i), bus.data_ready, 1'b0);
            @(negedge clk);
        end
        for (int g = 0; g < GAPC; g++) begin
            chk("gap_out", seq_out, 1'b0);
            chk("gap_act", seq_active, 1'b0);
            chk("gap_rdy", bus.data_ready, 1'b0);
            @(negedge clk);
        end
        chk("post_rdy", bus.data_ready, 1'b1);
    endtask

    initial begin
        int rise_at;
        bit seen;
        bit prev_act;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out", seq_out, 1'b0);
        chk("rst_act", seq_active, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_rdy", bus.data_ready, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_out", seq_out, 1'b0);
            chk("idle_act", seq_active, 1'b0);
            chk("idle_rdy", bus.data_ready, 1'b1);
        end

        run_frame(8'hA5);

        // back-to-back with valid held: 3C then C3
        bus.data_in    = 8'h3C;
        bus.data_valid = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = seq_active;
        end
        chk("b2b_start", seen, 1'b1);
        rise_at  = -1;
        prev_act = 1'b1;
        for (int k = 0; k < PER + LEN; k++) begin
            if (k == LEN) bus.data_in = 8'hC3;
            if (k < LEN)
                chk("b2b_a", seq_out, fbit(8'h3C, k));
            else if (k < PER)
                chk("b2b_gap", seq_out, 1'b0);
            else
                chk("b2b_b", seq_out, fbit(8'hC3, k - PER));
            if (seq_active && !prev_act && rise_at < 0) rise_at = k;
            prev_act = seq_active;
            @(negedge clk);
        end
        chk("b2b_period", rise_at, PER);
        bus.data_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = bus.data_ready;
        end
        chk("b2b_drain", seen, 1'b1);

        // reset on the 6th frame bit
        bus.data_in    = 8'h5A;
        bus.data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.data_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_act", seq_active, 1'b1);
        rst = 1'b0;
        #1;
        chk("abort_out", seq_out, 1'b0);
        chk("abort_act", seq_active, 1'b0);
        chk("abort_done", frame_done, 1'b0);
        chk("abort_rdy", bus.data_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_rdy", bus.data_ready, 1'b1);

        det_cnt = 0;
        run_frame(8'h00);
        chk("loop_det", det_cnt, 1);

`ifdef SEQ_GEN_PARITY_EN
        run_frame(8'h07);
        chk("par_bit", fbit(8'h07, LEN - 1), 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
